custom_axi_regif: RTL and testbench

AXI4-Lite slave front-end that sits directly upstream of the custom AXI IP and feeds its register interface. It terminates AXI-Lite write and read transactions and keeps a 32-bit shadow copy of each IP register. Writes produce one-cycle write-enable pulses with the full 32-bit register value. Reads return the IP's readback data.

---
 rtl/custom_axi_pkg.sv | 42 ++++
 rtl/custom_axi_regif.sv | 235 +++++++++++++++++++++++
 tb/tb_custom_axi_regif.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/custom_axi_pkg.sv
// Shared types, constants and helpers for the custom AXI IP register front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package custom_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers are 32-bit words packed at a 4-byte stride; the low address
  // bits below the stride never take part in decoding.
  localparam int unsigned REG_STRIDE = 4;
  localparam int unsigned STRIDE_LSB = $clog2(REG_STRIDE);

  typedef logic [31:0] reg_word_t;
  typedef logic [3:0]  reg_strb_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_PULSE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  // Replace only the bytes of old_word whose strobe bit is set.
  function automatic reg_word_t strb_merge(input reg_word_t old_word,
                                           input reg_word_t new_word,
                                           input reg_strb_t strb);
    reg_word_t res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/custom_axi_regif.sv
// AXI4-Lite slave holding 32-bit shadow registers and pulsing per-register write enables to the IP.
// Latency: bvalid 2 cycles after the later of AW/W; rvalid 1 cycle after AR.
// Backpressure: one outstanding write and one outstanding read; ready drops until the response handshakes.
module custom_axi_regif
  import custom_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_REGS   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic [ADDR_WIDTH-1:0]    s_awaddr_i,
  input  logic                     s_awvalid_i,
  output logic                     s_awready_o,
  input  logic [31:0]              s_wdata_i,
  input  logic [3:0]               s_wstrb_i,
  input  logic                     s_wvalid_i,
  output logic                     s_wready_o,
  output logic [1:0]               s_bresp_o,
  output logic                     s_bvalid_o,
  input  logic                     s_bready_i,

  input  logic [ADDR_WIDTH-1:0]    s_araddr_i,
  input  logic                     s_arvalid_i,
  output logic                     s_arready_o,
  output logic [31:0]              s_rdata_o,
  output logic [1:0]               s_rresp_o,
  output logic                     s_rvalid_o,
  input  logic                     s_rready_i,

  output logic [NUM_REGS*32-1:0]   reg2ip_data_o,
  output logic [NUM_REGS-1:0]      reg2ip_en_o,
  input  logic [NUM_REGS*32-1:0]   ip2reg_data_i,
  input  logic [NUM_REGS-1:0]      ip2reg_en_i
);

  localparam int unsigned IDX_W = ADDR_WIDTH - STRIDE_LSB;

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  w_state_e                    w_state_q, w_state_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q,  w_done_d;
  logic [IDX_W-1:0]            aw_idx_q,  aw_idx_d;
  reg_word_t                   wdata_q,   wdata_d;
  reg_strb_t                   wstrb_q,   wstrb_d;
  reg_word_t [NUM_REGS-1:0]    shadow_q,  shadow_d;
  logic [NUM_REGS-1:0]         en_q,      en_d;
  logic                        bvalid_q,  bvalid_d;
  logic [1:0]                  bresp_q,   bresp_d;

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  r_state_e                    r_state_q, r_state_d;
  logic                        rvalid_q,  rvalid_d;
  reg_word_t                   rdata_q,   rdata_d;
  logic [1:0]                  rresp_q,   rresp_d;

  reg_word_t [NUM_REGS-1:0]    ip_words;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        ar_hs;
  logic [IDX_W-1:0]            ar_idx;
  logic                        unused_addr_lsbs;

  assign ip_words = ip2reg_data_i;

  // Byte-offset bits only select a byte within the word, which the bus never
  // needs here: unaligned accesses hit the containing register.
  assign unused_addr_lsbs = ^{s_awaddr_i[STRIDE_LSB-1:0], s_araddr_i[STRIDE_LSB-1:0]};

  // Each channel is ready only while the write FSM idles and that channel has
  // not yet been captured, so AW and W can arrive in either order.
  assign s_awready_o = (w_state_q == W_IDLE) && !aw_done_q;
  assign s_wready_o  = (w_state_q == W_IDLE) && !w_done_q;
  assign s_arready_o = (r_state_q == R_IDLE);

  assign aw_hs  = s_awvalid_i && s_awready_o;
  assign w_hs   = s_wvalid_i  && s_wready_o;
  assign ar_hs  = s_arvalid_i && s_arready_o;
  assign ar_idx = s_araddr_i[ADDR_WIDTH-1:STRIDE_LSB];

  assign s_bvalid_o    = bvalid_q;
  assign s_bresp_o     = bresp_q;
  assign s_rvalid_o    = rvalid_q;
  assign s_rdata_o     = rdata_q;
  assign s_rresp_o     = rresp_q;
  assign reg2ip_data_o = shadow_q;
  assign reg2ip_en_o   = en_q;

  // Write FSM next state: capture AW/W independently, merge into the shadow
  // in W_PULSE (new value and enable appear together one cycle later), then
  // hold the response until the master takes it.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    shadow_d  = shadow_q;
    en_d      = '0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          aw_idx_d  = s_awaddr_i[ADDR_WIDTH-1:STRIDE_LSB];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = s_wdata_i;
          wstrb_d  = s_wstrb_i;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          w_state_d = W_PULSE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end

      W_PULSE: begin
        bresp_d = RESP_SLVERR;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          if (int'(aw_idx_q) == i) begin
            shadow_d[i] = strb_merge(shadow_q[i], wdata_q, wstrb_q);
            en_d[i]     = 1'b1;
            bresp_d     = RESP_OKAY;
          end
        end
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
      end

      W_RESP: begin
        if (s_bready_i) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end

      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Write path registers; reset aborts any pending pulse or response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      shadow_q  <= '0;
      en_q      <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      shadow_q  <= shadow_d;
      en_q      <= en_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read FSM next state: the response word is sampled in the AR handshake
  // cycle (IP readback if it flags valid, else the shadow) and then frozen
  // until the R handshake.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (int'(ar_idx) == i) begin
              rdata_d = ip2reg_en_i[i] ? ip_words[i] : shadow_q[i];
              rresp_d = RESP_OKAY;
            end
          end
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end

      R_RESP: begin
        if (s_rready_i) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end

      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Read path registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_custom_axi_regif.sv
// Directed bench for custom_axi_regif with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every wait on the DUT is bounded by a cycle budget.
module tb_custom_axi_regif;

  logic         clk_i;
  logic         rst_ni;
  logic [11:0]  s_awaddr_i;
  logic         s_awvalid_i;
  logic         s_awready_o;
  logic [31:0]  s_wdata_i;
  logic [3:0]   s_wstrb_i;
  logic         s_wvalid_i;
  logic         s_wready_o;
  logic [1:0]   s_bresp_o;
  logic         s_bvalid_o;
  logic         s_bready_i;
  logic [11:0]  s_araddr_i;
  logic         s_arvalid_i;
  logic         s_arready_o;
  logic [31:0]  s_rdata_o;
  logic [1:0]   s_rresp_o;
  logic         s_rvalid_o;
  logic         s_rready_i;
  logic [95:0]  reg2ip_data_o;
  logic [2:0]   reg2ip_en_o;
  logic [95:0]  ip2reg_data_i;
  logic [2:0]   ip2reg_en_i;

  int checks = 0;
  int errors = 0;
  logic [2:0]  en_seen;
  logic [1:0]  resp;
  logic [31:0] rdata;

  custom_axi_regif #(
    .ADDR_WIDTH (12),
    .NUM_REGS   (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_awaddr_i    (s_awaddr_i),
    .s_awvalid_i   (s_awvalid_i),
    .s_awready_o   (s_awready_o),
    .s_wdata_i     (s_wdata_i),
    .s_wstrb_i     (s_wstrb_i),
    .s_wvalid_i    (s_wvalid_i),
    .s_wready_o    (s_wready_o),
    .s_bresp_o     (s_bresp_o),
    .s_bvalid_o    (s_bvalid_o),
    .s_bready_i    (s_bready_i),
    .s_araddr_i    (s_araddr_i),
    .s_arvalid_i   (s_arvalid_i),
    .s_arready_o   (s_arready_o),
    .s_rdata_o     (s_rdata_o),
    .s_rresp_o     (s_rresp_o),
    .s_rvalid_o    (s_rvalid_o),
    .s_rready_i    (s_rready_i),
    .reg2ip_data_o (reg2ip_data_o),
    .reg2ip_en_o   (reg2ip_en_o),
    .ip2reg_data_i (ip2reg_data_i),
    .ip2reg_en_i   (ip2reg_en_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AW and W together, then wait (bounded) for B and accept it.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] bresp);
    bit got;
    got         = 1'b0;
    s_awaddr_i  = addr;
    s_wdata_i   = data;
    s_wstrb_i   = strb;
    s_awvalid_i = 1'b1;
    s_wvalid_i  = 1'b1;
    tick();
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
    en_seen     = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      en_seen = en_seen | reg2ip_en_o;
      if (s_bvalid_o) got = 1'b1;
    end
    chk("write_bvalid_arrives", {95'd0, got}, 96'd1);
    bresp      = s_bresp_o;
    s_bready_i = 1'b1;
    tick();
    s_bready_i = 1'b0;
  endtask

  // AR, expect R the next cycle, accept it.
  task automatic do_read(input logic [11:0] addr, output logic [31:0] data,
                         output logic [1:0] rresp);
    s_araddr_i  = addr;
    s_arvalid_i = 1'b1;
    tick();
    s_arvalid_i = 1'b0;
    chk("read_rvalid_next_cycle", {95'd0, s_rvalid_o}, 96'd1);
    data       = s_rdata_o;
    rresp      = s_rresp_o;
    s_rready_i = 1'b1;
    tick();
    s_rready_i = 1'b0;
    chk("read_arready_after_r", {95'd0, s_arready_o}, 96'd1);
  endtask

  initial begin
    rst_ni        = 1'b0;
    s_awaddr_i    = '0;
    s_awvalid_i   = 1'b0;
    s_wdata_i     = '0;
    s_wstrb_i     = '0;
    s_wvalid_i    = 1'b0;
    s_bready_i    = 1'b0;
    s_araddr_i    = '0;
    s_arvalid_i   = 1'b0;
    s_rready_i    = 1'b0;
    ip2reg_data_i = '0;
    ip2reg_en_i   = '0;
    en_seen       = '0;

    // Reset state
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_readies", {93'd0, s_awready_o, s_wready_o, s_arready_o}, 96'h7);
    chk("rst_valids", {94'd0, s_bvalid_o, s_rvalid_o}, 96'h0);
    chk("rst_shadows", reg2ip_data_o, 96'h0);
    chk("rst_en", {93'd0, reg2ip_en_o}, 96'h0);
    chk("rst_resp_data", {60'd0, s_bresp_o, s_rresp_o, s_rdata_o}, 96'h0);

    // Same-cycle AW+W to reg1
    s_awaddr_i  = 12'h004;
    s_wdata_i   = 32'hA5A5_0001;
    s_wstrb_i   = 4'hF;
    s_awvalid_i = 1'b1;
    s_wvalid_i  = 1'b1;
    tick();
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
    chk("t1_pulse_cycle_ready_low", {94'd0, s_awready_o, s_wready_o}, 96'h0);
    chk("t1_pulse_cycle_no_b", {94'd0, s_bvalid_o, |reg2ip_en_o}, 96'h0);
    tick();
    chk("t1_en", {93'd0, reg2ip_en_o}, 96'h2);
    chk("t1_data1", {64'd0, reg2ip_data_o[63:32]}, {64'd0, 32'hA5A5_0001});
    chk("t1_bvalid_bresp", {93'd0, s_bvalid_o, s_bresp_o}, {93'd0, 1'b1, 2'b00});
    tick();
    chk("t1_en_one_cycle", {93'd0, reg2ip_en_o}, 96'h0);
    chk("t1_bvalid_held", {95'd0, s_bvalid_o}, 96'd1);
    s_bready_i = 1'b1;
    tick();
    s_bready_i = 1'b0;
    chk("t1_b_done", {94'd0, s_bvalid_o, s_awready_o}, 96'h1);

    // AW first, W three cycles later, then a partial-strobe write
    s_awaddr_i  = 12'h000;
    s_awvalid_i = 1'b1;
    tick();
    s_awvalid_i = 1'b0;
    chk("t2_aw_latched", {94'd0, s_awready_o, s_wready_o}, 96'h1);
    tick();
    tick();
    chk("t2_awready_still_low", {95'd0, s_awready_o}, 96'h0);
    s_wdata_i  = 32'hFFFF_FFFF;
    s_wstrb_i  = 4'hF;
    s_wvalid_i = 1'b1;
    tick();
    s_wvalid_i = 1'b0;
    chk("t2_both_latched", {94'd0, s_awready_o, s_wready_o}, 96'h0);
    tick();
    chk("t2_en", {93'd0, reg2ip_en_o}, 96'h1);
    chk("t2_data0", {64'd0, reg2ip_data_o[31:0]}, {64'd0, 32'hFFFF_FFFF});
    chk("t2_bvalid_awready", {94'd0, s_bvalid_o, s_awready_o}, 96'h2);
    s_bready_i = 1'b1;
    tick();
    s_bready_i = 1'b0;
    chk("t2_awready_after_b", {95'd0, s_awready_o}, 96'd1);
    do_write(12'h000, 32'h1234_5678, 4'h3, resp);
    chk("t2_strb_resp", {94'd0, resp}, 96'h0);
    chk("t2_strb_merge", {64'd0, reg2ip_data_o[31:0]}, {64'd0, 32'hFFFF_5678});

    // Out-of-range write
    do_write(12'h00C, 32'hDEAD_BEEF, 4'hF, resp);
    chk("t3_slverr", {94'd0, resp}, 96'h2);
    chk("t3_no_pulse", {93'd0, en_seen}, 96'h0);
    chk("t3_shadows_kept", reg2ip_data_o, {32'h0, 32'hA5A5_0001, 32'hFFFF_5678});

    // Unaligned write selects containing word (0x9 -> reg2), strobes 0101
    do_write(12'h009, 32'h1122_3344, 4'b0101, resp);
    chk("t3b_resp", {94'd0, resp}, 96'h0);
    chk("t3b_pulse", {93'd0, en_seen}, 96'h4);
    chk("t3b_shadows", reg2ip_data_o, {32'h0022_0044, 32'hA5A5_0001, 32'hFFFF_5678});

    // Reads: IP readback valid, shadow fallback, out of range, unaligned
    ip2reg_data_i = {32'hCAFE_0002, 32'h1111_1111, 32'h2222_2222};
    ip2reg_en_i   = 3'b100;
    do_read(12'h008, rdata, resp);
    chk("t4_ip_readback", {62'd0, resp, rdata}, {62'd0, 2'b00, 32'hCAFE_0002});
    ip2reg_en_i = 3'b000;
    do_read(12'h008, rdata, resp);
    chk("t4_shadow_readback", {62'd0, resp, rdata}, {62'd0, 2'b00, 32'h0022_0044});
    do_read(12'h010, rdata, resp);
    chk("t4_out_of_range", {62'd0, resp, rdata}, {62'd0, 2'b10, 32'h0});
    do_read(12'h006, rdata, resp);
    chk("t4_unaligned", {62'd0, resp, rdata}, {62'd0, 2'b00, 32'hA5A5_0001});

    // Read captured in the W_PULSE cycle of a write to the same register
    s_awaddr_i  = 12'h004;
    s_wdata_i   = 32'h7777_7777;
    s_wstrb_i   = 4'hF;
    s_awvalid_i = 1'b1;
    s_wvalid_i  = 1'b1;
    tick();
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
    s_araddr_i  = 12'h004;
    s_arvalid_i = 1'b1;
    tick();
    s_arvalid_i = 1'b0;
    chk("t6_pulse_and_new_data", {61'd0, reg2ip_en_o, reg2ip_data_o[63:32]}, {61'd0, 3'b010, 32'h7777_7777});
    chk("t6_read_pre_write", {63'd0, s_rvalid_o, s_rdata_o}, {63'd0, 1'b1, 32'hA5A5_0001});
    s_bready_i = 1'b1;
    s_rready_i = 1'b1;
    tick();
    s_bready_i = 1'b0;
    s_rready_i = 1'b0;
    chk("t6_both_done", {94'd0, s_bvalid_o, s_rvalid_o}, 96'h0);

    // Concurrent write and read with both responses stalled 5 cycles
    s_awaddr_i  = 12'h000;
    s_wdata_i   = 32'h0BAD_F00D;
    s_wstrb_i   = 4'hF;
    s_awvalid_i = 1'b1;
    s_wvalid_i  = 1'b1;
    s_araddr_i  = 12'h004;
    s_arvalid_i = 1'b1;
    tick();
    s_awvalid_i   = 1'b0;
    s_wvalid_i    = 1'b0;
    s_arvalid_i   = 1'b0;
    ip2reg_data_i = {96{1'b1}};
    ip2reg_en_i   = 3'b111;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t5_stall_stable", {58'd0, s_bvalid_o, s_rvalid_o, s_bresp_o, s_rresp_o, s_rdata_o},
          {58'd0, 1'b1, 1'b1, 2'b00, 2'b00, 32'h7777_7777});
      tick();
    end
    s_bready_i = 1'b1;
    s_rready_i = 1'b1;
    tick();
    s_bready_i  = 1'b0;
    s_rready_i  = 1'b0;
    ip2reg_en_i = 3'b000;
    chk("t5_released", {94'd0, s_bvalid_o, s_rvalid_o}, 96'h0);
    chk("t5_shadow0", {64'd0, reg2ip_data_o[31:0]}, {64'd0, 32'h0BAD_F00D});

    // Reset while bvalid is pending
    s_awaddr_i  = 12'h008;
    s_wdata_i   = 32'h5555_AAAA;
    s_wstrb_i   = 4'hF;
    s_awvalid_i = 1'b1;
    s_wvalid_i  = 1'b1;
    tick();
    s_awvalid_i = 1'b0;
    s_wvalid_i  = 1'b0;
    tick();
    chk("t7_bvalid_before_rst", {95'd0, s_bvalid_o}, 96'd1);
    rst_ni = 1'b0;
    #1;
    chk("t7_bvalid_dropped", {95'd0, s_bvalid_o}, 96'd0);
    chk("t7_shadows_cleared", reg2ip_data_o, 96'h0);
    chk("t7_en_cleared", {93'd0, reg2ip_en_o}, 96'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t7_readies_after_rst", {93'd0, s_awready_o, s_wready_o, s_arready_o}, 96'h7);
    do_write(12'h008, 32'h0000_0001, 4'hF, resp);
    chk("t7_recovered_write", {62'd0, resp, reg2ip_data_o[95:64]}, {62'd0, 2'b00, 32'h1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
